// File: rtl/scoreboard_hazard.sv
// Register scoreboard: tracks cycles until each register's in-flight result
// is usable, stalls issue on RAW/WAW hazards and selects bypass operands.
module scoreboard_hazard #(
    parameter int REG_NUM = 32,
    parameter int AW      = 5,
    parameter int SRC_NUM = 2,
    parameter int LAT_W   = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [SRC_NUM-1:0]     issue_src_rd,
    input  logic [SRC_NUM*AW-1:0]  issue_src_addr,
    input  logic                   issue_dst_we,
    input  logic [AW-1:0]          issue_dst_addr,
    input  logic [LAT_W-1:0]       issue_lat,
    output logic                   issue_ready,
    output logic [SRC_NUM-1:0]     fwd_sel,
    input  logic                   flush,
    output logic                   pending_any
);

    localparam int ADDR_SPACE = 2 ** AW;

    // One counter per encodable address. Entry 0 and any address at or above
    // REG_NUM are held at zero so lookups never need a range check.
    logic [LAT_W-1:0] cnt [ADDR_SPACE];

    logic raw_hazard;
    logic waw_hazard;
    logic issue_fire;

    assign issue_fire = issue_valid & issue_ready;

    // Per-register countdown: reload on a fired write, otherwise count to zero.
    always_ff @(posedge clk) begin
        for (int r = 0; r < ADDR_SPACE; r++) begin
            // NOTE: every counter is reset; this is flop state that gates
            // issue, not a RAM, so leaving it unknown would block the pipe.
            if (rst || flush) begin
                cnt[r] <= '0;
            end else if (r == 0 || r >= REG_NUM) begin
                cnt[r] <= '0;
            end else if (issue_fire && issue_dst_we && issue_dst_addr == AW'(r)) begin
                // Reload wins over the decrement of the same register.
                cnt[r] <= issue_lat;
            end else if (cnt[r] != '0) begin
                // NOTE: non-blocking so every counter updates from the
                // pre-edge value regardless of loop order.
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    // Hazard detection and bypass selection, purely from current state.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned and
        // no latch is inferred.
        raw_hazard  = 1'b0;
        fwd_sel     = '0;
        pending_any = 1'b0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (issue_src_rd[i] && cnt[issue_src_addr[i*AW +: AW]] > LAT_W'(1)) begin
                raw_hazard = 1'b1;
            end
            if (issue_src_rd[i] && cnt[issue_src_addr[i*AW +: AW]] == LAT_W'(1)) begin
                fwd_sel[i] = 1'b1;
            end
        end
        waw_hazard = issue_dst_we && (issue_dst_addr != '0)
                     && (cnt[issue_dst_addr] > issue_lat);
        for (int r = 1; r < ADDR_SPACE; r++) begin
            if (cnt[r] != '0) begin
                pending_any = 1'b1;
            end
        end
        issue_ready = ~flush & ~raw_hazard & ~waw_hazard;
    end

endmodule

// File: doc/scoreboard_hazard.md
Name: scoreboard_hazard

Overview:
- Parametrised register scoreboard that gates instruction issue in the next-generation pipelined CPU.
- Sits between IDU decode and EXU.
- Tracks the remaining cycles until each register's in-flight result is available.
- Stalls on RAW and WAW hazards and tells the datapath which source operands must take the bypass path instead of the register file.

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width, clog2(REG_NUM).
- SRC_NUM, 2, number of source operands per instruction.
- LAT_W, 3, width of the per-register latency counter; maximum latency is 2^LAT_W-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decode presents an instruction.
- issue_src_rd  in  SRC_NUM  per-source read enable (regaRd/regbRd style); source i is bit i.
- issue_src_addr  in  SRC_NUM*AW  source addresses; source i is slice [i*AW +: AW].
- issue_dst_we  in  1  instruction writes a register.
- issue_dst_addr  in  AW  destination register.
- issue_lat  in  LAT_W  cycles after issue until the result can be bypassed (ALU=1, load=2).
- issue_ready  out  1  issue accepted this cycle; issue fires when issue_valid & issue_ready.
- fwd_sel  out  SRC_NUM  bit i=1: source i must use the bypass value this cycle.
- flush  in  1  squash all in-flight tracking (branch/jump redirect).
- pending_any  out  1  at least one register is pending.

Behaviour:
- State: per-register counter cnt[r], LAT_W bits, for r=1..REG_NUM-1. cnt[0] is constant 0.
- Reset (rst=1 at posedge): all cnt <= 0. Outputs are combinational from state, so after reset issue_ready=1 whenever no hazard exists, fwd_sel=0 and pending_any=0.
- Meaning of cnt:
  - 0 = value is in the register file.
  - 1 = value is available on the bypass path this cycle.
  - >=2 = value is not yet available.
- RAW stall: source i hazards if issue_src_rd[i] & cnt[src_i] >= 2.
- WAW stall: hazard if issue_dst_we & dst!=0 & cnt[dst] > issue_lat.
- issue_ready = ~flush & no RAW hazard & no WAW hazard. issue_ready is independent of issue_valid.
- fwd_sel[i] = issue_src_rd[i] & cnt[src_i]==1. This is independent of issue_valid and is 0 for source address 0.
- Per-clock update (priority from highest):
  1. rst: all counters <= 0.
  2. flush: all counters <= 0. Any issue in the same cycle is ignored (issue_ready is already 0).
  3. Otherwise, every nonzero cnt decrements by 1. If the issue fires with dst_we & dst!=0, then cnt[dst] <= issue_lat. This assignment overrides the decrement of the same register.
- Edge cases:
  - issue_lat=0: the register is not marked pending; cnt[dst] <= 0.
  - A source equal to its own destination is checked against the pre-issue count (old value).
  - A stalled instruction holds: no counter is written. Counters still decrement, so the stall resolves without further action.
  - Counters saturate at 0; no wrap below 0.
  - issue_lat at its maximum (2^LAT_W-1) is legal.
- pending_any = OR over all cnt[r]!=0.
- Latency: the issue decision and fwd_sel are in the same cycle (0-cycle combinational from state). State effects are visible the next cycle.
- Mid-operation rst behaves like flush and additionally takes priority over it.

Test Plan:
- Reset then idle: rst high 2 cycles, then issue_valid=1, src r3/r4 enabled, nothing pending → issue_ready=1, fwd_sel=00, pending_any=0.
- Load-use: issue r5<-load with lat=2; next cycle issue src0=r5 → issue_ready=0, fwd_sel[0]=0. The cycle after → issue_ready=1, fwd_sel[0]=1. The cycle after that (no issue) → cnt[r5]=0, pending_any=0.
- Back-to-back ALU: issue r7 lat=1; next cycle src1=r7, src0=r2 → issue_ready=1, fwd_sel=10.
- WAW: issue r8 lat=3; next cycle (cnt[r8]=2) issue dst=r8 lat=1 → stall. The cycle after (cnt[r8]=1) → issue_ready=1 and cnt[r8] is reloaded to 1.
- Flush: r9 pending lat=3, assert flush with issue_valid=1 → issue_ready=0 that cycle. Next cycle → pending_any=0 and src=r9 gives issue_ready=1, fwd_sel=0.
- Register 0: issue dst=r0 lat=2 → pending_any stays 0. A subsequent src=r0 never stalls and fwd_sel=0.
